// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_controller_pkg
// Shared definitions for the multicycle ARM-subset controller:
//   - FSM state encoding
//   - ALUControl codes (must match the ALU's decode)
//   - data-processing cmd codes, Op codes, condition codes
//   - helper functions: data-processing cmd decode and condition evaluation
// -----------------------------------------------------------------------------
package multicycle_controller_pkg;

    localparam int CMD_W = 4;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Data-processing cmd field Funct[4:1]
    localparam logic [CMD_W-1:0] CMD_AND = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_CMP = 4'b1010;
    localparam logic [CMD_W-1:0] CMD_SLT = 4'b1011;
    localparam logic [CMD_W-1:0] CMD_ORR = 4'b1100;

    // Op field Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Condition field Instr[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Decoded view of a data-processing cmd
    typedef struct packed {
        logic       legal;     // cmd is implemented
        logic [2:0] alu_ctl;   // ALUControl to drive in EXECUTE
        logic       no_write;  // result is not written back (CMP)
        logic       arith;     // instruction may update C and V
    } dp_dec_t;

    function automatic dp_dec_t decode_cmd(input logic [CMD_W-1:0] cmd);
        dp_dec_t d;
        d.legal    = 1'b1;
        d.alu_ctl  = ALU_ADD;
        d.no_write = 1'b0;
        d.arith    = 1'b0;
        case (cmd)
            CMD_ADD: begin d.alu_ctl = ALU_ADD; d.arith = 1'b1; end
            CMD_SUB: begin d.alu_ctl = ALU_SUB; d.arith = 1'b1; end
            CMD_AND: begin d.alu_ctl = ALU_AND; end
            CMD_ORR: begin d.alu_ctl = ALU_OR;  end
            CMD_CMP: begin d.alu_ctl = ALU_SUB; d.arith = 1'b1; d.no_write = 1'b1; end
            CMD_SLT: begin d.alu_ctl = ALU_SLT; end
            default: begin d.legal = 1'b0; end
        endcase
        return d;
    endfunction

    // ARM condition evaluation against flags {N,Z,C,V}; 1111 never executes
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v, r;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = c & ~z;
            COND_LS: r = ~c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_unit.sv
// -----------------------------------------------------------------------------
// multicycle_controller_cond_unit
// Holds the architectural {N,Z,C,V} flag register and evaluates the current
// instruction's condition against it.
// Ports:
//   clk, rst   clock, async active-high reset (flags cleared)
//   Cond       condition field of the current instruction
//   ALUFlags   {N,Z,C,V} produced by the ALU this cycle
//   FlagW      [1] load N,Z   [0] load C,V
//   FlagEn     high in the cycle whose ALU flags may be captured
//   CondEx     condition passes against the registered (pre-instruction) flags
// -----------------------------------------------------------------------------
module multicycle_controller_cond_unit
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       FlagEn,
    output logic       CondEx
);

    logic [3:0] r_flags;

    // Evaluated from the stored flags so the instruction's own result never
    // influences its condition.
    assign CondEx = cond_eval(Cond, r_flags);

    // Flag register: N,Z and C,V groups load independently, only when the
    // instruction actually executes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 4'b0000;
        end else begin
            if (FlagEn && CondEx && FlagW[1]) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (FlagEn && CondEx && FlagW[0]) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for the multicycle ARM-subset datapath. Sequences each
// instruction through FETCH..WRITEBACK, decodes IR fields into ALUControl,
// mux selects and write enables, and gates architectural writes on the
// instruction's condition.
// Ports:
//   clk, rst     clock, async active-high reset
//   Cond/Op/Funct/Rd   IR fields [31:28]/[27:26]/[25:20]/[15:12]
//   ALUFlags     {N,Z,C,V} from the ALU
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//   ALUSrcB, ALUControl, ImmSrc, RegSrc   datapath controls
//   Illegal      one-cycle pulse in DECODE for unsupported encodings
// -----------------------------------------------------------------------------
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter logic [3:0] PC_REG = 4'd15
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       Illegal
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CMD_W-1:0]   w_cmd;
    dp_dec_t            w_dec;
    logic               w_s_eff;
    logic [1:0]         w_flag_w;
    logic               w_flag_en;
    logic               w_cond_ex;
    logic               w_rd_is_pc;
    logic               w_dp_wr;
    logic               w_pc_write;
    logic               w_mem_write;
    logic               w_ir_write;
    logic               w_reg_write;

    assign w_cmd      = Funct[4:1];
    assign w_dec      = decode_cmd(w_cmd);
    // CMP always sets flags even when the S bit is clear
    assign w_s_eff    = Funct[0] | (w_cmd == CMD_CMP);
    assign w_flag_w   = {w_s_eff, w_s_eff & w_dec.arith};
    assign w_rd_is_pc = (Rd == PC_REG);
    assign w_dp_wr    = w_cond_ex & ~w_dec.no_write;

    assign ImmSrc = Op;
    assign RegSrc = {(Op == OP_MEM), (Op == OP_BR)};

    // Write enables are held off for the whole reset pulse so an aborted
    // instruction cannot leak a write.
    assign PCWrite  = w_pc_write  & ~rst;
    assign MemWrite = w_mem_write & ~rst;
    assign IRWrite  = w_ir_write  & ~rst;
    assign RegWrite = w_reg_write & ~rst;

    multicycle_controller_cond_unit u_cond (
        .clk      (clk),
        .rst      (rst),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (w_flag_w),
        .FlagEn   (w_flag_en),
        .CondEx   (w_cond_ex)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        w_next_state = S_FETCH;
        w_pc_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_flag_en    = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUControl   = ALU_ADD;
        Illegal      = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC <= PC+4 while the instruction is latched into IR
                w_ir_write   = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                w_pc_write   = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // PC+4 again so R15 reads as PC+8
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    OP_DP: begin
                        if (!w_dec.legal) begin
                            Illegal      = 1'b1;
                            w_next_state = S_FETCH;
                        end else if (Funct[5]) begin
                            w_next_state = S_EXECUTEI;
                        end else begin
                            w_next_state = S_EXECUTER;
                        end
                    end
                    OP_MEM:  w_next_state = S_MEMADR;
                    OP_BR:   w_next_state = S_BRANCH;
                    default: begin
                        Illegal      = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_EXECUTER: begin
                ALUControl   = w_dec.alu_ctl;
                w_flag_en    = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB      = 2'b01;
                ALUControl   = w_dec.alu_ctl;
                w_flag_en    = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                // A write to PC_REG is steered to the PC instead of the file
                w_pc_write   = w_dp_wr & w_rd_is_pc;
                w_reg_write  = w_dp_wr & ~w_rd_is_pc;
                w_next_state = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB      = 2'b01;
                w_next_state = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc       = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                w_pc_write   = w_cond_ex & w_rd_is_pc;
                w_reg_write  = w_cond_ex & ~w_rd_is_pc;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc       = 1'b1;
                w_mem_write  = w_cond_ex;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB      = 2'b01;
                ResultSrc    = 2'b10;
                w_pc_write   = w_cond_ex;
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Illegal;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;

    int checks   = 0;
    int failures = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .Illegal(Illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; Cond = 4'b1110; Op = 2'b00; Funct = 6'b000000; Rd = 4'd0; ALUFlags = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
            failures++; $display("FAIL reset_we got=%b exp=%b", {PCWrite, MemWrite, IRWrite, RegWrite}, 4'b0000);
        end
        checks++;
        if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl} !== {1'b0, 1'b1, 2'b10, 2'b10, 3'b000}) begin
            failures++; $display("FAIL reset_fetch_ctl got=%b exp=%b", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}, {1'b0, 1'b1, 2'b10, 2'b10, 3'b000});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b1010) begin
            failures++; $display("FAIL release_fetch got=%b exp=%b", {PCWrite, MemWrite, IRWrite, RegWrite}, 4'b1010);
        end
    endtask

    task automatic test_branch(input logic [3:0] c, input logic exp_pc, input string nm);
        Cond = c; Op = 2'b10; Funct = 6'b100000; Rd = 4'd0;
        tick();
        checks++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite, Illegal, ImmSrc, RegSrc} !== {5'b00000, 2'b10, 2'b01}) begin
            failures++; $display("FAIL %s_decode got=%b exp=%b", nm, {PCWrite, MemWrite, IRWrite, RegWrite, Illegal, ImmSrc, RegSrc}, {5'b00000, 2'b10, 2'b01});
        end
        tick();
        checks++;
        if ({PCWrite, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, RegWrite, MemWrite} !== {exp_pc, 1'b0, 2'b01, 3'b000, 2'b10, 2'b00}) begin
            failures++; $display("FAIL %s_branch got=%b exp=%b", nm, {PCWrite, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, RegWrite, MemWrite}, {exp_pc, 1'b0, 2'b01, 3'b000, 2'b10, 2'b00});
        end
        tick();
        checks++;
        if ({IRWrite, PCWrite} !== 2'b11) begin
            failures++; $display("FAIL %s_latency got=%b exp=%b", nm, {IRWrite, PCWrite}, 2'b11);
        end
    endtask

    task automatic test_dp(input logic i, input logic [3:0] cmd, input logic s, input logic [3:0] rd,
                           input logic [3:0] c, input logic [3:0] flags_in, input logic [2:0] exp_alu,
                           input logic exp_regw, input logic exp_pcw, input string nm);
        Cond = c; Op = 2'b00; Funct = {i, cmd, s}; Rd = rd;
        tick();
        checks++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite, Illegal, ALUSrcA, ALUSrcB, ResultSrc} !== {5'b00000, 1'b1, 2'b10, 2'b10}) begin
            failures++; $display("FAIL %s_decode got=%b exp=%b", nm, {PCWrite, MemWrite, IRWrite, RegWrite, Illegal, ALUSrcA, ALUSrcB, ResultSrc}, {5'b00000, 1'b1, 2'b10, 2'b10});
        end
        tick();
        ALUFlags = flags_in;
        checks++;
        if ({ALUControl, ALUSrcA, ALUSrcB, PCWrite, RegWrite} !== {exp_alu, 1'b0, (i ? 2'b01 : 2'b00), 2'b00}) begin
            failures++; $display("FAIL %s_execute got=%b exp=%b", nm, {ALUControl, ALUSrcA, ALUSrcB, PCWrite, RegWrite}, {exp_alu, 1'b0, (i ? 2'b01 : 2'b00), 2'b00});
        end
        tick();
        ALUFlags = 4'b1111;
        checks++;
        if ({PCWrite, RegWrite, MemWrite, ResultSrc} !== {exp_pcw, exp_regw, 1'b0, 2'b00}) begin
            failures++; $display("FAIL %s_aluwb got=%b exp=%b", nm, {PCWrite, RegWrite, MemWrite, ResultSrc}, {exp_pcw, exp_regw, 1'b0, 2'b00});
        end
        tick();
        checks++;
        if ({IRWrite, PCWrite} !== 2'b11) begin
            failures++; $display("FAIL %s_latency got=%b exp=%b", nm, {IRWrite, PCWrite}, 2'b11);
        end
    endtask

    task automatic test_mem(input logic l, input logic [3:0] c, input logic exp_we, input string nm);
        Cond = c; Op = 2'b01; Funct = {1'b0, 4'b1100, l}; Rd = 4'd2;
        tick();
        checks++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite, ImmSrc, RegSrc} !== {4'b0000, 2'b01, 2'b10}) begin
            failures++; $display("FAIL %s_decode got=%b exp=%b", nm, {PCWrite, MemWrite, IRWrite, RegWrite, ImmSrc, RegSrc}, {4'b0000, 2'b01, 2'b10});
        end
        tick();
        checks++;
        if ({ALUSrcA, ALUSrcB, ALUControl, AdrSrc, MemWrite, RegWrite} !== {1'b0, 2'b01, 3'b000, 3'b000}) begin
            failures++; $display("FAIL %s_memadr got=%b exp=%b", nm, {ALUSrcA, ALUSrcB, ALUControl, AdrSrc, MemWrite, RegWrite}, {1'b0, 2'b01, 3'b000, 3'b000});
        end
        if (l) begin
            tick();
            checks++;
            if ({AdrSrc, MemWrite, RegWrite} !== 3'b100) begin
                failures++; $display("FAIL %s_memrd got=%b exp=%b", nm, {AdrSrc, MemWrite, RegWrite}, 3'b100);
            end
            tick();
            checks++;
            if ({ResultSrc, RegWrite, PCWrite, MemWrite} !== {2'b01, exp_we, 2'b00}) begin
                failures++; $display("FAIL %s_memwb got=%b exp=%b", nm, {ResultSrc, RegWrite, PCWrite, MemWrite}, {2'b01, exp_we, 2'b00});
            end
        end else begin
            tick();
            checks++;
            if ({AdrSrc, MemWrite, RegWrite, PCWrite} !== {1'b1, exp_we, 2'b00}) begin
                failures++; $display("FAIL %s_memwr got=%b exp=%b", nm, {AdrSrc, MemWrite, RegWrite, PCWrite}, {1'b1, exp_we, 2'b00});
            end
        end
        tick();
        checks++;
        if ({IRWrite, PCWrite} !== 2'b11) begin
            failures++; $display("FAIL %s_latency got=%b exp=%b", nm, {IRWrite, PCWrite}, 2'b11);
        end
    endtask

    task automatic test_illegal(input logic [1:0] op, input logic [5:0] fn, input string nm);
        Cond = 4'b1110; Op = op; Funct = fn; Rd = 4'd1;
        tick();
        checks++;
        if ({Illegal, PCWrite, MemWrite, IRWrite, RegWrite} !== 5'b10000) begin
            failures++; $display("FAIL %s_decode got=%b exp=%b", nm, {Illegal, PCWrite, MemWrite, IRWrite, RegWrite}, 5'b10000);
        end
        tick();
        checks++;
        if ({Illegal, IRWrite, PCWrite, RegWrite, MemWrite} !== 5'b01100) begin
            failures++; $display("FAIL %s_next_fetch got=%b exp=%b", nm, {Illegal, IRWrite, PCWrite, RegWrite, MemWrite}, 5'b01100);
        end
    endtask

    task automatic test_rst_memwr();
        Cond = 4'b1110; Op = 2'b01; Funct = 6'b011000; Rd = 4'd2;
        tick();
        tick();
        tick();
        checks++;
        if ({AdrSrc, MemWrite} !== 2'b11) begin
            failures++; $display("FAIL rst_memwr_pre got=%b exp=%b", {AdrSrc, MemWrite}, 2'b11);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b0000) begin
            failures++; $display("FAIL rst_memwr_abort got=%b exp=%b", {PCWrite, MemWrite, IRWrite, RegWrite}, 4'b0000);
        end
        tick();
        checks++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc} !== 5'b00000) begin
            failures++; $display("FAIL rst_memwr_hold got=%b exp=%b", {PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc}, 5'b00000);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({PCWrite, MemWrite, IRWrite, RegWrite} !== 4'b1010) begin
            failures++; $display("FAIL rst_memwr_refetch got=%b exp=%b", {PCWrite, MemWrite, IRWrite, RegWrite}, 4'b1010);
        end
    endtask

    initial begin
        test_reset();
        // flags cleared by reset: Z=0
        test_branch(4'b0000, 1'b0, "beq_after_reset");
        test_branch(4'b0001, 1'b1, "bne_after_reset");
        // ADD R1 without S: ALU flags present but must not be stored
        test_dp(1'b0, 4'b0100, 1'b0, 4'd1, 4'b1110, 4'b1111, 3'b000, 1'b1, 1'b0, "add");
        test_branch(4'b0000, 1'b0, "beq_after_add_nos");
        // CMP loads Z=1 -> flags 0100
        test_dp(1'b0, 4'b1010, 1'b0, 4'd0, 4'b1110, 4'b0100, 3'b001, 1'b0, 1'b0, "cmp");
        test_branch(4'b0000, 1'b1, "beq_after_cmp");
        test_branch(4'b0001, 1'b0, "bne_after_cmp");
        test_branch(4'b0100, 1'b0, "bmi_after_cmp");
        test_branch(4'b1001, 1'b1, "bls_after_cmp");
        test_branch(4'b1100, 1'b0, "bgt_after_cmp");
        test_branch(4'b1110, 1'b1, "bal");
        test_branch(4'b1111, 1'b0, "bnv");
        // memory
        test_mem(1'b1, 4'b1110, 1'b1, "ldr");
        test_mem(1'b0, 4'b0001, 1'b0, "str_ne_false");
        test_mem(1'b0, 4'b1110, 1'b1, "str_al");
        // SUBS immediate -> flags 0010; ORRS loads only N,Z -> flags 1110
        test_dp(1'b1, 4'b0010, 1'b1, 4'd3, 4'b1110, 4'b0010, 3'b001, 1'b1, 1'b0, "subs_imm");
        test_dp(1'b0, 4'b1100, 1'b1, 4'd4, 4'b1110, 4'b1101, 3'b011, 1'b1, 1'b0, "orrs");
        test_branch(4'b0010, 1'b1, "bcs");
        test_branch(4'b0110, 1'b0, "bvs");
        test_branch(4'b0100, 1'b1, "bmi");
        test_branch(4'b1000, 1'b0, "bhi");
        test_branch(4'b1010, 1'b0, "bge");
        test_branch(4'b1011, 1'b1, "blt");
        test_branch(4'b1101, 1'b1, "ble");
        // ANDS with failing condition: no write, flags untouched
        test_dp(1'b0, 4'b0000, 1'b1, 4'd5, 4'b0001, 4'b0000, 3'b010, 1'b0, 1'b0, "ands_ne_false");
        test_branch(4'b0000, 1'b1, "beq_after_condfail");
        test_dp(1'b0, 4'b1011, 1'b0, 4'd6, 4'b1110, 4'b1111, 3'b101, 1'b1, 1'b0, "slt");
        // PC destination and never-condition
        test_dp(1'b0, 4'b0100, 1'b0, 4'd15, 4'b1110, 4'b1111, 3'b000, 1'b0, 1'b1, "add_pc");
        test_dp(1'b0, 4'b0100, 1'b0, 4'd1, 4'b1111, 4'b1111, 3'b000, 1'b0, 1'b0, "add_nv");
        // illegal encodings
        test_illegal(2'b11, 6'b000000, "op11");
        test_illegal(2'b00, 6'b000010, "cmd_eor");
        test_rst_memwr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
